// File: rtl/clock_divider_controller.sv
// clock_divider_controller: runtime-programmable /2../16 clock divider with glitch-free factor switching
module clock_divider_controller #(
  parameter int COUNTER_WIDTH = 4,
  parameter logic [1:0] DEFAULT_SEL = 2'b00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] factor_sel,
  input  logic       factor_valid,
  output logic       factor_ready,
  output logic       clock_d,
  output logic       tick,
  output logic [1:0] active_sel,
  output logic       busy
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state;
  logic [1:0] pending;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [COUNTER_WIDTH-1:0] h_m1;
  assign h_m1 = (COUNTER_WIDTH'(1) << active_sel) - COUNTER_WIDTH'(1);
  // Divider plus IDLE/PENDING switch controller; a pending factor is applied only at the end of a high phase
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
      clock_d <= 1'b0;
      tick <= 1'b0;
      active_sel <= DEFAULT_SEL;
      pending <= DEFAULT_SEL;
      state <= IDLE;
      factor_ready <= 1'b1;
      busy <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (state == IDLE && factor_valid) begin
        pending <= factor_sel;
        state <= PENDING;
        factor_ready <= 1'b0;
        busy <= 1'b1;
      end
      if (enable) begin
        if (counter == h_m1) begin
          counter <= '0;
          if (state == PENDING && clock_d) begin
            clock_d <= 1'b0;
            active_sel <= pending;
            state <= IDLE;
            factor_ready <= 1'b1;
            busy <= 1'b0;
          end else begin
            clock_d <= ~clock_d;
            tick <= ~clock_d;
          end
        end else begin
          counter <= counter + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_clock_divider_controller.sv
// tb_clock_divider_controller: directed self-checking bench for clock_divider_controller
module tb_clock_divider_controller;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic [1:0] factor_sel = 2'b00;
  logic factor_valid = 1'b0;
  logic factor_ready, clock_d, tick, busy;
  logic [1:0] active_sel;
  int vectors = 0;
  int miscompares = 0;

  clock_divider_controller #(.COUNTER_WIDTH(4), .DEFAULT_SEL(2'b00)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .factor_sel(factor_sel),
    .factor_valid(factor_valid),
    .factor_ready(factor_ready),
    .clock_d(clock_d),
    .tick(tick),
    .active_sel(active_sel),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic bsy, input logic [1:0] sel);
    chk({tag, ".ready"}, {3'b0, factor_ready}, {3'b0, rdy});
    chk({tag, ".busy"}, {3'b0, busy}, {3'b0, bsy});
    chk({tag, ".active_sel"}, {2'b0, active_sel}, {2'b0, sel});
  endtask

  task automatic run(input string tag, input int n, input logic [31:0] cd_pat, input logic [31:0] tk_pat);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk($sformatf("%s.clock_d[%0d]", tag, i), {3'b0, clock_d}, {3'b0, cd_pat[n-1-i]});
      chk($sformatf("%s.tick[%0d]", tag, i), {3'b0, tick}, {3'b0, tk_pat[n-1-i]});
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst.clock_d", {3'b0, clock_d}, 4'h0);
    chk("rst.tick", {3'b0, tick}, 4'h0);
    chk_ctl("rst", 1'b1, 1'b0, 2'b00);
    reset_n = 1'b1;
    run("div2", 4, 4'b1010, 4'b1010);
    chk_ctl("div2", 1'b1, 1'b0, 2'b00);
    factor_sel = 2'b10;
    factor_valid = 1'b1;
    run("req8", 1, 1'b1, 1'b1);
    chk_ctl("req8.acc", 1'b0, 1'b1, 2'b00);
    factor_valid = 1'b0;
    run("sw8", 1, 1'b0, 1'b0);
    chk_ctl("sw8.done", 1'b1, 1'b0, 2'b10);
    run("div8", 8, 8'b00011110, 8'b00010000);
    factor_sel = 2'b11;
    factor_valid = 1'b1;
    run("req16", 1, 1'b0, 1'b0);
    chk_ctl("req16.acc", 1'b0, 1'b1, 2'b10);
    factor_valid = 1'b0;
    run("pend16", 6, 6'b001111, 6'b001000);
    run("sw16", 1, 1'b0, 1'b0);
    chk_ctl("sw16.done", 1'b1, 1'b0, 2'b11);
    run("div16", 8, 8'b00000001, 8'b00000001);
    factor_sel = 2'b01;
    factor_valid = 1'b1;
    run("req4", 1, 1'b1, 1'b0);
    chk_ctl("req4.acc", 1'b0, 1'b1, 2'b11);
    factor_valid = 1'b0;
    run("sw4", 13, 13'b1111110011001, 13'b0000000010001);
    chk_ctl("sw4.done", 1'b1, 1'b0, 2'b01);
    enable = 1'b0;
    run("frozen", 5, 5'b11111, 5'b00000);
    enable = 1'b1;
    run("resume", 4, 4'b1001, 4'b0001);
    factor_sel = 2'b10;
    factor_valid = 1'b1;
    run("req8b", 1, 1'b1, 1'b0);
    chk_ctl("req8b.acc", 1'b0, 1'b1, 2'b01);
    factor_sel = 2'b11;
    run("sw8b", 1, 1'b0, 1'b0);
    chk_ctl("sw8b.held", 1'b1, 1'b0, 2'b10);
    run("acc16b", 1, 1'b0, 1'b0);
    chk_ctl("acc16b", 1'b0, 1'b1, 2'b10);
    factor_valid = 1'b0;
    run("sw16b", 15, 15'b001111000000001, 15'b001000000000001);
    chk_ctl("sw16b.done", 1'b1, 1'b0, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("rst2.clock_d", {3'b0, clock_d}, 4'h0);
    chk_ctl("rst2", 1'b1, 1'b0, 2'b00);
    @(negedge clock);
    reset_n = 1'b1;
    run("div2b", 2, 2'b10, 2'b10);
    factor_sel = 2'b10;
    factor_valid = 1'b1;
    run("req8c", 1, 1'b1, 1'b1);
    chk_ctl("req8c.acc", 1'b0, 1'b1, 2'b00);
    reset_n = 1'b0;
    factor_valid = 1'b0;
    #1;
    chk("rst3.clock_d", {3'b0, clock_d}, 4'h0);
    chk("rst3.tick", {3'b0, tick}, 4'h0);
    chk_ctl("rst3", 1'b1, 1'b0, 2'b00);
    @(negedge clock);
    reset_n = 1'b1;
    run("div2c", 6, 6'b101010, 6'b101010);
    chk_ctl("div2c", 1'b1, 1'b0, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
